// File: rtl/pe_bypass_pkg.sv
// Shared constants and types for the PE operand bypass network:
// result-source indices, default latencies and the scoreboard slot layout.
package pe_bypass_pkg;

  localparam int PE_DW      = 32;
  localparam int PE_AW      = 5;
  localparam int PE_NUM_SRC = 4;
  localparam int PE_SRC_W   = 2;
  localparam int PE_DEPTH   = 4;
  localparam int PE_NUM_NB  = 4;
  localparam int PE_NB_SELW = 3;
  localparam int PE_R_NOBYP = 1;

  localparam logic [PE_SRC_W-1:0] SRC_ALU    = 2'd0;
  localparam logic [PE_SRC_W-1:0] SRC_MUL    = 2'd1;
  localparam logic [PE_SRC_W-1:0] SRC_LSU    = 2'd2;
  localparam logic [PE_SRC_W-1:0] SRC_SHADOW = 2'd3;

  // 4 bits per source, src3 in the top nibble: SHADOW=2, LSU=2, MUL=1, ALU=1.
  localparam logic [4*PE_NUM_SRC-1:0] PE_SRC_LAT = 16'h2211;

  typedef struct packed {
    logic                v;
    logic [PE_AW-1:0]    addr;
    logic [PE_SRC_W-1:0] src;
  } slot_t;

  function automatic int lat_of(input logic [4*PE_NUM_SRC-1:0] lat,
                                input logic [PE_SRC_W-1:0]     src);
    return int'(lat[int'(src)*4 +: 4]);
  endfunction

endpackage

// File: rtl/pe_bypass_sb_slots.sv
// In-flight write scoreboard: a shift register of issued RF writes plus a
// youngest-first match for the two operand read ports.
module pe_bypass_sb_slots
  import pe_bypass_pkg::*;
#(
  parameter int                        DEPTH   = PE_DEPTH,
  parameter logic [4*PE_NUM_SRC-1:0]   SRC_LAT = PE_SRC_LAT,
  parameter int                        R_NOBYP = PE_R_NOBYP
) (
  input  logic                iClk,
  input  logic                iReset,
  input  logic                iFlush,
  input  logic                iPush,
  input  logic [PE_AW-1:0]    iPush_Addr,
  input  logic [PE_SRC_W-1:0] iPush_Src,
  input  logic [PE_AW-1:0]    iLook_Addr_A,
  input  logic [PE_AW-1:0]    iLook_Addr_B,
  output logic                oHit_A,
  output logic                oHazard_A,
  output logic [PE_SRC_W-1:0] oSrc_A,
  output logic                oHit_B,
  output logic                oHazard_B,
  output logic [PE_SRC_W-1:0] oSrc_B
);

  localparam logic [PE_AW-1:0] R_LAST = PE_AW'(R_NOBYP);

  typedef slot_t slot_arr_t [1:DEPTH];

  typedef struct packed {
    logic                hit;
    logic                hazard;
    logic [PE_SRC_W-1:0] src;
  } look_t;

  slot_arr_t slot_q;
  slot_arr_t slot_d;
  look_t     look_a;
  look_t     look_b;

  // Slot k holds the write issued k cycles ago; it drops out once its result
  // has had its single forwarding cycle and the WB port/RF take over.
  always_comb begin
    slot_d[1] = '{v: iPush, addr: iPush_Addr, src: iPush_Src};
    for (int k = 2; k <= DEPTH; k++) begin
      slot_d[k]   = slot_q[k-1];
      slot_d[k].v = slot_q[k-1].v && (k <= lat_of(SRC_LAT, slot_q[k-1].src));
    end
  end

  always_ff @(posedge iClk) begin
    if (iReset || iFlush) begin
      // NOTE: only the valid bits are cleared; addr/src of an invalid slot are
      // never looked at, so that payload needs no reset.
      for (int k = 1; k <= DEPTH; k++) begin
        slot_q[k].v <= 1'b0;
      end
    end else begin
      // NOTE: state registers use non-blocking assignment so every slot
      // samples its neighbour's old value and the shift is one step per clock.
      slot_q <= slot_d;
    end
  end

  function automatic look_t lookup(input slot_arr_t s, input logic [PE_AW-1:0] addr);
    look_t r;
    r = '0;
    // Oldest first, so the youngest match is the one left standing.
    for (int k = DEPTH; k >= 1; k--) begin
      if (s[k].v && (s[k].addr == addr) && (addr > R_LAST)) begin
        r.hit    = 1'b1;
        r.hazard = (k < lat_of(SRC_LAT, s[k].src));
        r.src    = s[k].src;
      end
    end
    return r;
  endfunction

  always_comb begin
    look_a = lookup(slot_q, iLook_Addr_A);
    look_b = lookup(slot_q, iLook_Addr_B);
  end

  assign oHit_A    = look_a.hit;
  assign oHazard_A = look_a.hazard;
  assign oSrc_A    = look_a.src;
  assign oHit_B    = look_b.hit;
  assign oHazard_B = look_b.hazard;
  assign oSrc_B    = look_b.src;

endmodule

// File: rtl/pe_bypass_sb.sv
// PE operand bypass network: scoreboard-driven forwarding, load/MUL-use
// stall, neighbour/CP operand-A select, RSUBI swap and the ID operand register.
module pe_bypass_sb
  import pe_bypass_pkg::*;
#(
  parameter int                      DW      = PE_DW,
  parameter logic [4*PE_NUM_SRC-1:0] SRC_LAT = PE_SRC_LAT,
  parameter int                      DEPTH   = PE_DEPTH,
  parameter int                      NUM_NB  = PE_NUM_NB,
  parameter int                      NB_SELW = PE_NB_SELW,
  parameter int                      R_NOBYP = PE_R_NOBYP
) (
  input  logic                     iClk,
  input  logic                     iReset,
  input  logic                     iFlush,
  input  logic                     iIssue_Valid,
  output logic                     oIssue_Ready,
  input  logic [PE_AW-1:0]         iRd_Addr_A,
  input  logic [PE_AW-1:0]         iRd_Addr_B,
  input  logic                     iSel_Imm,
  input  logic                     iIs_SUB,
  input  logic [DW-1:0]            iImmediate,
  input  logic                     iWr_En,
  input  logic [PE_AW-1:0]         iWr_Addr,
  input  logic [PE_SRC_W-1:0]      iWr_Src,
  input  logic [DW-1:0]            iRF_Data_A,
  input  logic [DW-1:0]            iRF_Data_B,
  input  logic [PE_NUM_SRC*DW-1:0] iSrc_Result,
  input  logic                     iWB_En,
  input  logic [PE_AW-1:0]         iWB_Addr,
  input  logic [DW-1:0]            iWB_Data,
  input  logic [NB_SELW-1:0]       iData_Selection,
  input  logic [NUM_NB*DW-1:0]     iNb_Data,
  input  logic [DW-1:0]            iCP_Data,
  output logic                     oOp_Valid,
  output logic [DW-1:0]            oOperand_A,
  output logic [DW-1:0]            oOperand_B,
  output logic [DW-1:0]            oStore_Data,
  output logic [DW-1:0]            oPort1_Data
);

  localparam logic [PE_AW-1:0] R_LAST = PE_AW'(R_NOBYP);

  logic                hit_a, haz_a, hit_b, haz_b;
  logic [PE_SRC_W-1:0] src_a, src_b;
  logic                wb_a, wb_b;
  logic [DW-1:0]       fwd_a, fwd_b, byp_a, byp_b;
  logic [DW-1:0]       nbsel_a, op_b_pre;
  logic                nb_sel, check_b, accept, push, rsubi;
  int                  sel_idx;

  logic          op_valid_q, op_valid_d;
  logic [DW-1:0] op_a_q, op_a_d;
  logic [DW-1:0] op_b_q, op_b_d;
  logic [DW-1:0] st_q, st_d;

  assign push = accept && iWr_En && (iWr_Addr > R_LAST);

  pe_bypass_sb_slots #(
    .DEPTH   (DEPTH),
    .SRC_LAT (SRC_LAT),
    .R_NOBYP (R_NOBYP)
  ) u_slots (
    .iClk         (iClk),
    .iReset       (iReset),
    .iFlush       (iFlush),
    .iPush        (push),
    .iPush_Addr   (iWr_Addr),
    .iPush_Src    (iWr_Src),
    .iLook_Addr_A (iRd_Addr_A),
    .iLook_Addr_B (iRd_Addr_B),
    .oHit_A       (hit_a),
    .oHazard_A    (haz_a),
    .oSrc_A       (src_a),
    .oHit_B       (hit_b),
    .oHazard_B    (haz_b),
    .oSrc_B       (src_b)
  );

  assign fwd_a = iSrc_Result[int'(src_a)*DW +: DW];
  assign fwd_b = iSrc_Result[int'(src_b)*DW +: DW];
  assign wb_a  = iWB_En && (iWB_Addr == iRd_Addr_A) && (iRd_Addr_A > R_LAST);
  assign wb_b  = iWB_En && (iWB_Addr == iRd_Addr_B) && (iRd_Addr_B > R_LAST);

  // A scoreboard hit always beats the WB port; a hit still in flight has no
  // usable value yet, so the RF data is passed through until the stall clears.
  assign byp_a = (hit_a && !haz_a) ? fwd_a : (!hit_a && wb_a) ? iWB_Data : iRF_Data_A;
  assign byp_b = (hit_b && !haz_b) ? fwd_b : (!hit_b && wb_b) ? iWB_Data : iRF_Data_B;

  assign oPort1_Data = byp_a;

  assign sel_idx = int'(iData_Selection);
  assign nb_sel  = (sel_idx >= 1) && (sel_idx <= NUM_NB + 1);

  always_comb begin
    // NOTE: a default is assigned before any branch so no path leaves the
    // output unassigned, which would otherwise infer a latch.
    nbsel_a = byp_a;
    for (int k = 0; k < NUM_NB; k++) begin
      if (sel_idx == k + 1) nbsel_a = iNb_Data[k*DW +: DW];
    end
    if (sel_idx == NUM_NB + 1) nbsel_a = iCP_Data;
  end

  // There is no store flag: an immediate op that writes the RF cannot be a
  // store, anything else might be and must keep its store-data B checked.
  assign check_b      = !(iSel_Imm && iWr_En);
  assign oIssue_Ready = !((haz_a && !nb_sel) || (haz_b && check_b));
  assign accept       = iIssue_Valid && oIssue_Ready;

  assign rsubi    = iIs_SUB && iSel_Imm;
  assign op_b_pre = iSel_Imm ? iImmediate : byp_b;

  always_comb begin
    op_valid_d = accept && !iFlush;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    st_d       = st_q;
    if (accept && !iFlush) begin
      op_a_d = rsubi ? iImmediate : nbsel_a;
      op_b_d = rsubi ? nbsel_a    : op_b_pre;
      st_d   = byp_b;
    end
  end

  always_ff @(posedge iClk) begin
    if (iReset) begin
      op_valid_q <= 1'b0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      st_q       <= '0;
    end else begin
      op_valid_q <= op_valid_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      st_q       <= st_d;
    end
  end

  assign oOp_Valid   = op_valid_q;
  assign oOperand_A  = op_a_q;
  assign oOperand_B  = op_b_q;
  assign oStore_Data = st_q;

endmodule
